// File: rtl/pitch_to_bcd_pkg.sv
// Shared constants and the double-dabble digit adjust used by the pitch display path.
// Latency: n/a (constants and pure function only).
// Backpressure: n/a.
package pitch_to_bcd_pkg;

    localparam int SAMPLE_RATE_HZ_DEFAULT = 8000;
    localparam int BCD_DIGITS_DEFAULT     = 4;
    localparam int DATA_WIDTH_BITS        = 16;
    localparam int MAX_TAU                = 255;

    localparam logic [DATA_WIDTH_BITS-1:0] BCD_MAX = 16'd9999;

    // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pitch_to_bcd_bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double-dabble).
// Latency: 16 cycles after the start edge, done pulses for one cycle.
// Backpressure: none; a new start restarts the conversion.
module bin2bcd_seq
    import pitch_to_bcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [15:0] bin_sr;
    logic [3:0]  cnt;
    logic        active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr <= '0;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_sr <= bin;
                bcd    <= '0;
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                // Inputs are at most 9999, so the top adjusted bit never carries out.
                bcd    <= 16'({dd_adjust(bcd), bin_sr[15]});
                bin_sr <= {bin_sr[14:0], 1'b0};
                cnt    <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pitch_to_bcd.sv
// Converts a pitch period in samples to its frequency in Hz as 4 packed BCD digits.
// Latency: bcd_valid 33 cycles after the accept edge; 34-cycle back-to-back throughput.
// Backpressure: none; tau_valid is dropped while busy.
module pitch_to_bcd
    import pitch_to_bcd_pkg::*;
#(
    parameter int SAMPLE_RATE_HZ = SAMPLE_RATE_HZ_DEFAULT,
    parameter int TAU_WIDTH      = 8,
    parameter int BCD_DIGITS     = BCD_DIGITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tau_valid,
    input  logic [TAU_WIDTH-1:0]    tau,
    output logic                    busy,
    output logic                    bcd_valid,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH_BITS-1:0] DIVIDEND = DATA_WIDTH_BITS'(SAMPLE_RATE_HZ);

    state_t                     state, state_nxt;
    logic [3:0]                 cnt;
    logic [TAU_WIDTH-1:0]       divisor;
    logic [TAU_WIDTH-1:0]       rem, rem_nxt;
    logic [TAU_WIDTH:0]         rem_sh;
    logic [DATA_WIDTH_BITS-1:0] quot, quot_nxt, quot_sat;
    logic                       q_bit;
    logic                       sat;
    logic                       ovf_pend;

    logic                       b2b_start;
    logic                       b2b_done;
    logic [15:0]                b2b_bcd;

    // Restoring division step: dividend bits shift out of quot's top while
    // quotient bits shift in at the bottom. A zero divisor never produces a 1.
    always_comb begin
        rem_sh   = {rem, quot[DATA_WIDTH_BITS-1]};
        q_bit    = (divisor != '0) && (rem_sh >= {1'b0, divisor});
        rem_nxt  = q_bit ? TAU_WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[TAU_WIDTH-1:0];
        quot_nxt = {quot[DATA_WIDTH_BITS-2:0], q_bit};
        sat      = (quot_nxt > BCD_MAX);
        quot_sat = sat ? BCD_MAX : quot_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tau_valid)     state_nxt = DIVIDE;
            DIVIDE:  if (cnt == 4'd15)  state_nxt = CONVERT;
            CONVERT: if (cnt == 4'd15)  state_nxt = DONE;
            DONE:                       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign b2b_start = (state == DIVIDE) && (cnt == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            divisor   <= '0;
            rem       <= '0;
            quot      <= '0;
            ovf_pend  <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tau_valid) begin
                        divisor <= tau;
                        quot    <= DIVIDEND;
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                DIVIDE: begin
                    quot <= quot_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        ovf_pend <= sat;
                    end
                end
                CONVERT: cnt <= cnt + 4'd1;
                DONE: begin
                    if (b2b_done) begin
                        bcd       <= b2b_bcd;
                        overflow  <= ovf_pend;
                        bcd_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (b2b_start),
        .bin   (quot_sat),
        .done  (b2b_done),
        .bcd   (b2b_bcd)
    );

endmodule

// File: tb/tb_pitch_to_bcd.sv
// Scoreboard bench for pitch_to_bcd at 8 kHz and 20 kHz sample rates.
module tb_pitch_to_bcd;
    import pitch_to_bcd_pkg::*;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          vcyc;
        int          tau;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tv8, tv20;
    logic [7:0]  tau8, tau20;
    logic        busy8, v8, ovf8, busy20, v20, ovf20;
    logic [15:0] bcd8, bcd20;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   next_ok [2];
    int   last_acc [2];
    exp_t q8 [$];
    exp_t q20 [$];

    pitch_to_bcd #(.SAMPLE_RATE_HZ(8000), .TAU_WIDTH(8), .BCD_DIGITS(4)) dut8 (
        .clk(clk), .reset(reset), .tau_valid(tv8), .tau(tau8),
        .busy(busy8), .bcd_valid(v8), .bcd(bcd8), .overflow(ovf8)
    );

    pitch_to_bcd #(.SAMPLE_RATE_HZ(20000), .TAU_WIDTH(8), .BCD_DIGITS(4)) dut20 (
        .clk(clk), .reset(reset), .tau_valid(tv20), .tau(tau20),
        .busy(busy20), .bcd_valid(v20), .bcd(bcd20), .overflow(ovf20)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, saturation, decimal digit split.
    function automatic exp_t model(input int sr, input int t, input int acc_edge);
        exp_t e;
        int   f;
        f     = (t == 0) ? 0 : sr / t;
        e.ovf = (f > 9999);
        if (f > 9999) f = 9999;
        e.bcd  = {4'(f / 1000), 4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10)};
        e.tau  = t;
        e.vcyc = acc_edge + 33;
        return e;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h want %h at cycle %0d", name, idx, act, req, cyc);
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic [15:0] b, input logic o, input logic bz);
        exp_t e;
        logic bz_exp;
        bz_exp = (cyc >= last_acc[idx]) && (cyc <= last_acc[idx] + 32);
        check("busy", idx, 32'(bz), 32'(bz_exp));
        for (int d = 0; d < 4; d++) check("digit_over_9", idx, 32'(b[d*4 +: 4] > 4'd9), 32'(0));
        if (idx == 0 && q8.size() > 0 && q8[0].vcyc < cyc) begin
            e = q8.pop_front();
            check("missing_valid_tau", idx, 32'(0), 32'(e.tau + 1));
        end
        if (idx == 1 && q20.size() > 0 && q20[0].vcyc < cyc) begin
            e = q20.pop_front();
            check("missing_valid_tau", idx, 32'(0), 32'(e.tau + 1));
        end
        if (v !== 1'b0) begin
            if ((idx == 0 && q8.size() == 0) || (idx == 1 && q20.size() == 0)) begin
                check("unexpected_valid", idx, 32'(v), 32'(0));
            end else begin
                if (idx == 0) e = q8.pop_front();
                else          e = q20.pop_front();
                check("bcd", idx, 32'(b), 32'(e.bcd));
                check("overflow", idx, 32'(o), 32'(e.ovf));
                check("valid_cycle", idx, 32'(cyc), 32'(e.vcyc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, v8, bcd8, ovf8, busy8);
            mon(1, v20, bcd20, ovf20, busy20);
        end
    end

    task automatic drive(input int idx, input logic v, input int t);
        if (idx == 0) begin tv8 = v;  tau8 = 8'(t);  end
        else          begin tv20 = v; tau20 = 8'(t); end
    endtask

    task automatic accept(input int idx, input int t);
        exp_t e;
        e = model((idx == 0) ? 8000 : 20000, t, cyc + 1);
        if (idx == 0) q8.push_back(e);
        else          q20.push_back(e);
        last_acc[idx] = cyc + 1;
        next_ok[idx]  = cyc + 35;
    endtask

    task automatic strobe(input int idx, input int t);
        drive(idx, 1'b1, t);
        if (cyc + 1 >= next_ok[idx]) accept(idx, t);
        @(negedge clk);
        drive(idx, 1'b0, 0);
    endtask

    task automatic wait_idle(input int idx);
        while (cyc + 1 < next_ok[idx]) @(negedge clk);
    endtask

    // tau_valid held high with fresh random tau every cycle: max throughput.
    task automatic stress(input int idx, input int n);
        int acc = 0;
        int t;
        while (acc < n) begin
            t = int'($urandom_range(0, MAX_TAU));
            drive(idx, 1'b1, t);
            if (cyc + 1 >= next_ok[idx]) begin
                accept(idx, t);
                acc++;
            end
            @(negedge clk);
        end
        drive(idx, 1'b0, 0);
    endtask

    task automatic clear_models();
        q8.delete();
        q20.delete();
        for (int i = 0; i < 2; i++) begin
            next_ok[i]  = 0;
            last_acc[i] = -1000;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tv8 = 1'b0; tv20 = 1'b0; tau8 = '0; tau20 = '0;
        clear_models();
        repeat (3) @(negedge clk);
        check("rst_busy", 0, 32'(busy8), 32'(0));
        check("rst_valid", 0, 32'(v8), 32'(0));
        check("rst_bcd", 0, 32'(bcd8), 32'(0));
        check("rst_overflow", 0, 32'(ovf8), 32'(0));
        check("rst_busy", 1, 32'(busy20), 32'(0));
        reset = 1'b0;

        // Accepted on the first edge after release; tau=5 ten cycles later is dropped.
        strobe(0, 40);
        repeat (9) @(negedge clk);
        strobe(0, 5);
        wait_idle(0); strobe(0, 3);
        wait_idle(0); strobe(0, 1);
        wait_idle(0); strobe(0, 0);
        wait_idle(0); strobe(0, 255);

        strobe(1, 1);
        wait_idle(1); strobe(1, 4);
        wait_idle(1); strobe(1, 3);
        wait_idle(0); wait_idle(1);
        repeat (2) @(negedge clk);

        // Reset pulse mid-conversion must abort without a result.
        strobe(0, 8);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        clear_models();
        #1;
        check("midrst_busy", 0, 32'(busy8), 32'(0));
        check("midrst_valid", 0, 32'(v8), 32'(0));
        check("midrst_bcd", 0, 32'(bcd8), 32'(0));
        check("midrst_overflow", 0, 32'(ovf8), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        strobe(0, 8);
        wait_idle(0);

        fork
            stress(0, 500);
            stress(1, 40);
        join

        for (int i = 0; i < 100 && (q8.size() > 0 || q20.size() > 0); i++) @(negedge clk);
        check("drain_pending_8k", 0, 32'(q8.size()), 32'(0));
        check("drain_pending_20k", 1, 32'(q20.size()), 32'(0));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
